// File: rtl/piso_serializer.sv
// Parallel-in/serial-out word serializer with valid/ready on both sides, MSB first.
// Optional trailing even-parity bit per frame when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int unsigned NBITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_last,
    output logic             busy
);

    localparam int unsigned CW = $clog2(NBITS + 1);
`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME = NBITS + 1;
`else
    localparam int unsigned FRAME = NBITS;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [NBITS-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             armed;
    logic             word_acc;
    logic             bit_acc;
`ifdef PISO_PARITY_EN
    logic             par_q, par_nxt;
`endif

    // State and datapath registers; armed keeps word_ready low until the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            shreg <= '0;
            count <= '0;
            armed <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            count <= count_nxt;
            armed <= 1'b1;
`ifdef PISO_PARITY_EN
            par_q <= par_nxt;
`endif
        end
    end

    // Handshake decode, outputs and next-state logic.
    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        count_nxt  = count;
        busy       = 1'b0;
        bit_valid  = 1'b0;
        bit_last   = 1'b0;
        bit_out    = 1'b0;
        word_ready = 1'b0;
`ifdef PISO_PARITY_EN
        par_nxt    = par_q;
`endif

        if (state == S_SHIFT) begin
            busy      = 1'b1;
            bit_valid = 1'b1;
            bit_last  = (count == LAST_CNT);
            bit_out   = shreg[NBITS-1];
`ifdef PISO_PARITY_EN
            if (count == CW'(NBITS)) begin
                bit_out = par_q;
            end
`endif
            word_ready = bit_ready && bit_last;
        end else begin
            word_ready = armed;
        end

        word_acc = word_valid && word_ready;
        bit_acc  = bit_valid && bit_ready;

        case (state)
            S_IDLE: begin
                if (word_acc) begin
                    shreg_nxt = word_in;
                    count_nxt = '0;
                    state_nxt = S_SHIFT;
`ifdef PISO_PARITY_EN
                    par_nxt   = ^word_in;
`endif
                end
            end
            S_SHIFT: begin
                if (bit_acc) begin
                    if (!bit_last) begin
                        shreg_nxt = {shreg[NBITS-2:0], 1'b0};
                        count_nxt = count + CW'(1);
                    end else if (word_acc) begin
                        // Zero-bubble reload: next frame's first bit follows immediately.
                        shreg_nxt = word_in;
                        count_nxt = '0;
`ifdef PISO_PARITY_EN
                        par_nxt   = ^word_in;
`endif
                    end else begin
                        count_nxt = '0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer at NBITS=8 (parity-aware via PISO_PARITY_EN).
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FR = 9;
`else
    localparam int FR = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] word_in;
    logic       word_valid;
    logic       word_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready;
    logic       bit_last;
    logic       busy;

    int nerr = 0;
    int nchk = 0;

    piso_serializer #(.NBITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_last   (bit_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and wait (bounded) for it to be accepted.
    task automatic send_word(input logic [7:0] w);
        int n;
        word_in    = w;
        word_valid = 1'b1;
        n = 0;
        while (!word_ready && n < 20) begin
            step();
            n++;
        end
        check("send_ready", word_ready, 1'b1);
        step();
        word_valid = 1'b0;
    endtask

    // Consume n bits; exp holds data bits in [8:1] and the parity bit in [0].
    task automatic take_bits(input string tag, input logic [8:0] exp, input int n, input bit stall);
        logic [7:0] sipo;
        logic       held;
        sipo = '0;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, bit_valid, 1'b1);
            check({tag, "_bit"}, bit_out, exp[8-i]);
            check({tag, "_last"}, bit_last, (i == FR - 1));
            if (stall) begin
                held      = bit_out;
                bit_ready = 1'b0;
                step();
                check({tag, "_stall_bit"}, bit_out, held);
                check({tag, "_stall_last"}, bit_last, (i == FR - 1));
                check({tag, "_stall_busy"}, busy, 1'b1);
                bit_ready = 1'b1;
            end
            if (i < 8) sipo = {sipo[6:0], bit_out};
            step();
        end
        if (n == FR) check({tag, "_sipo"}, sipo, exp[8:1]);
    endtask

    initial begin
        rst_n      = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        bit_ready  = 1'b1;

        // Reset state
        step();
        step();
        check("rst_word_ready", word_ready, 1'b0);
        check("rst_bit_valid", bit_valid, 1'b0);
        check("rst_bit_out", bit_out, 1'b0);
        check("rst_bit_last", bit_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        #2;
        check("pre_edge_ready", word_ready, 1'b0);
        step();
        check("post_rst_ready", word_ready, 1'b1);

        // Single word, MSB first, SIPO recovers it
        send_word(8'hA5);
        take_bits("a5", {8'b1010_0101, 1'b0}, FR, 1'b0);
        check("a5_idle_valid", bit_valid, 1'b0);
        check("a5_idle_ready", word_ready, 1'b1);

        // Back-to-back 0xFF then 0x00 with no bubble
        word_in    = 8'hFF;
        word_valid = 1'b1;
        step();
        word_in = 8'h00;
        for (int i = 0; i < 2 * FR; i++) begin
            check("b2b_valid", bit_valid, 1'b1);
            check("b2b_bit", bit_out, (i < 8) ? 1'b1 : 1'b0);
            check("b2b_ready", word_ready, ((i % FR) == FR - 1));
            step();
            if (i == FR - 1) word_valid = 1'b0;
        end
        check("b2b_end_valid", bit_valid, 1'b0);

        // Stalled consumer: every bit held through its stall cycle
        send_word(8'h3C);
        take_bits("3c", {8'b0011_1100, 1'b0}, FR, 1'b1);
        check("3c_idle_busy", busy, 1'b0);

        // Word offered mid-frame is held off until the bit_last consume
        send_word(8'h55);
        for (int i = 0; i < FR; i++) begin
            if (i == 2) begin
                word_in    = 8'h99;
                word_valid = 1'b1;
            end
            check("hold_ready", word_ready, ((i >= 2) && (i == FR - 1)));
            check("hold_bit", bit_out, (i < 8) ? ((i % 2) == 1) : 1'b0);
            step();
        end
        word_valid = 1'b0;
        word_in    = 8'h00;
        take_bits("99", {8'b1001_1001, 1'b0}, FR, 1'b0);
        check("99_idle_valid", bit_valid, 1'b0);

        // Reset mid-frame aborts; next word starts clean
        send_word(8'hF0);
        take_bits("f0", {8'b1111_0000, 1'b0}, 3, 1'b0);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", bit_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", word_ready, 1'b0);
        rst_n = 1'b1;
        step();
        send_word(8'h81);
        take_bits("81", {8'b1000_0001, 1'b0}, FR, 1'b0);

`ifdef PISO_PARITY_EN
        // Parity bit appended as the last bit
        send_word(8'h07);
        take_bits("p07", {8'b0000_0111, 1'b1}, FR, 1'b0);
        send_word(8'h03);
        take_bits("p03", {8'b0000_0011, 1'b0}, FR, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
